// File: rtl/nibble_serial_add_ctrl.sv
// Sequencer that computes a WIDTH-bit add/subtract one nibble per clock, LSB first,
// by time-sharing a single external 4-bit adder cell through a registered carry chain.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             c_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [3:0] nib_a, nib_b;
    logic       run;

    // The adder-cell operands come only from registers, so there is no
    // combinational loop through the external cell.
    assign run   = (state_q == S_RUN);
    assign nib_a = a_q[{idx_q, 2'b00} +: 4];
    assign nib_b = b_q[{idx_q, 2'b00} +: 4] ^ {4{sub_q}};

    assign add_a    = run ? nib_a : 4'd0;
    assign add_b    = run ? nib_b : 4'd0;
    assign add_cin  = run ? carry_q : 1'b0;
    assign busy     = run;
    assign done     = (state_q == S_DONE);
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

    always_comb begin
        // NOTE: every target gets a hold default first, so no path infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    carry_d = sub ? 1'b1 : c_in;
                    idx_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d[{idx_q, 2'b00} +: 4] = add_sum;
                carry_d = add_cout;
                idx_d   = idx_q + 1'b1;
                // Published results move only on the last nibble; acc holds partials.
                if (idx_q == IDX_LAST) begin
                    sum_d   = acc_d;
                    c_out_d = add_cout;
                    ovf_d   = add_cout ^ (nib_a[3] ^ nib_b[3] ^ add_sum[3]);
                    zero_d  = (acc_d == '0);
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: directed 16-bit cases plus randomized 64-bit ops
// checked against an arithmetic reference model; each instance drives its own adder cell.
module tb_nibble_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic        st16 = 0, sub16 = 0, cin16 = 0;
    logic [15:0] a16 = 0, b16 = 0, sum16;
    logic [3:0]  aa16, ab16, asum16;
    logic        acin16, acout16, busy16, done16, cout16, ovf16, zero16;

    logic        st64 = 0, sub64 = 0, cin64 = 0;
    logic [63:0] a64 = 0, b64 = 0, sum64;
    logic [3:0]  aa64, ab64, asum64;
    logic        acin64, acout64, busy64, done64, cout64, ovf64, zero64;

    assign {acout16, asum16} = 5'(aa16) + 5'(ab16) + 5'(acin16);
    assign {acout64, asum64} = 5'(aa64) + 5'(ab64) + 5'(acin64);

    nibble_serial_add_ctrl #(.WIDTH(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .sub(sub16), .c_in(cin16),
        .a(a16), .b(b16), .add_a(aa16), .add_b(ab16), .add_cin(acin16),
        .add_sum(asum16), .add_cout(acout16), .busy(busy16), .done(done16),
        .sum(sum16), .c_out(cout16), .overflow(ovf16), .zero(zero16)
    );

    nibble_serial_add_ctrl #(.WIDTH(64)) u_d64 (
        .clk(clk), .rst_n(rst_n), .start(st64), .sub(sub64), .c_in(cin64),
        .a(a64), .b(b64), .add_a(aa64), .add_b(ab64), .add_cin(acin64),
        .add_sum(asum64), .add_cout(acout64), .busy(busy64), .done(done64),
        .sum(sum64), .c_out(cout64), .overflow(ovf64), .zero(zero64)
    );

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int w, input bit st, input logic [63:0] a, input logic [63:0] b,
                         input bit s, input bit c);
        if (w == 16) begin
            st16 = st; a16 = a[15:0]; b16 = b[15:0]; sub16 = s; cin16 = c;
        end else begin
            st64 = st; a64 = a; b64 = b; sub64 = s; cin64 = c;
        end
    endtask

    function automatic bit get_done(input int w);
        return (w == 16) ? done16 : done64;
    endfunction

    function automatic bit get_busy(input int w);
        return (w == 16) ? busy16 : busy64;
    endfunction

    task automatic get_res(input int w, output logic [63:0] s, output bit co, output bit ov,
                           output bit z);
        if (w == 16) begin
            s = 64'(sum16); co = cout16; ov = ovf16; z = zero16;
        end else begin
            s = sum64; co = cout64; ov = ovf64; z = zero64;
        end
    endtask

    // Whole-word arithmetic: add or two's-complement subtract, modulo 2^w.
    task automatic model(input int w, input logic [63:0] a, input logic [63:0] b, input bit s,
                         input bit c, output logic [63:0] rs, output bit co, output bit ov,
                         output bit z);
        logic [64:0] mask, bb, full;
        bit am, bm, sm;
        mask = (65'd1 << w) - 65'd1;
        bb   = s ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
        full = ({1'b0, a} & mask) + bb + 65'(s ? 1'b1 : c);
        co   = full[w];
        rs   = full[63:0] & mask[63:0];
        am   = a[w-1];
        bm   = b[w-1];
        sm   = rs[w-1];
        ov   = s ? (am != bm && sm != am) : (am == bm && sm != am);
        z    = (rs == 64'd0);
    endtask

    task automatic full_op(input int w, input logic [63:0] a, input logic [63:0] b, input bit s,
                           input bit c, output logic [63:0] got_sum);
        int lat, bc;
        logic [63:0] es, gs;
        bit eco, eov, ez, gco, gov, gz;
        @(negedge clk);
        drive(w, 1'b1, a, b, s, c);
        lat = 0;
        bc  = 0;
        while (lat < w + 10) begin
            @(negedge clk);
            if (lat == 0) drive(w, 1'b0, a, b, s, c);
            lat++;
            if (get_busy(w)) bc++;
            if (get_done(w)) break;
        end
        chk("latency", 65'(lat), 65'(w / 4 + 1));
        chk("busy_cycles", 65'(bc), 65'(w / 4));
        model(w, a, b, s, c, es, eco, eov, ez);
        get_res(w, gs, gco, gov, gz);
        chk("sum", 65'(gs), 65'(es));
        chk("c_out", 65'(gco), 65'(eco));
        chk("overflow", 65'(gov), 65'(eov));
        chk("zero", 65'(gz), 65'(ez));
        @(negedge clk);
        chk("done_one_cycle", 65'(get_done(w)), 65'd0);
        got_sum = gs;
    endtask

    initial begin
        logic [63:0] r, ra, rb;
        int dcnt, d1, d2, busy_gap;
        bit rs, rc;

        repeat (2) @(negedge clk);
        chk("reset_outs", 65'({sum16, busy16, done16, cout16, ovf16, zero16, aa16, ab16, acin16}),
            65'd0);
        rst_n = 1'b1;

        full_op(16, 64'h00FF, 64'h0001, 1'b0, 1'b0, r);
        chk("t1_sum", 65'(r), 65'h0100);
        full_op(16, 64'hFFFF, 64'h0001, 1'b0, 1'b0, r);
        chk("wrap_flags", 65'({sum16, cout16, zero16, ovf16}), 65'({16'h0000, 3'b110}));
        full_op(16, 64'h7FFF, 64'h0000, 1'b0, 1'b1, r);
        chk("ovf_flags", 65'({sum16, cout16, ovf16}), 65'({16'h8000, 2'b01}));
        full_op(16, 64'h8000, 64'h0001, 1'b1, 1'b0, r);
        chk("sub_flags", 65'({sum16, cout16, ovf16}), 65'({16'h7FFF, 2'b11}));
        full_op(16, 64'h0003, 64'h0005, 1'b1, 1'b0, r);
        chk("borrow_flags", 65'({sum16, cout16, ovf16}), 65'({16'hFFFE, 2'b00}));

        // start pulsed mid-RUN is ignored
        @(negedge clk);
        drive(16, 1'b1, 64'h1111, 64'h2222, 1'b0, 1'b0);
        dcnt = 0; d1 = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) drive(16, 1'b0, 64'h1111, 64'h2222, 1'b0, 1'b0);
            if (i == 2) drive(16, 1'b1, 64'hFFFF, 64'hFFFF, 1'b1, 1'b1);
            if (i == 3) drive(16, 1'b0, 64'hFFFF, 64'hFFFF, 1'b1, 1'b1);
            if (done16) begin dcnt++; if (d1 == 0) d1 = i; end
        end
        chk("midrun_done_count", 65'(dcnt), 65'd1);
        chk("midrun_latency", 65'(d1), 65'd5);
        chk("midrun_sum", 65'(sum16), 65'h3333);

        // start held through DONE restarts with no IDLE gap
        @(negedge clk);
        drive(16, 1'b1, 64'h0101, 64'h0202, 1'b0, 1'b0);
        d1 = 0; d2 = 0; busy_gap = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 1) drive(16, 1'b1, 64'h1000, 64'h0F00, 1'b0, 1'b0);
            if (done16 && d1 == 0) begin
                d1 = i;
                chk("b2b_first_sum", 65'(sum16), 65'h0303);
            end else if (done16 && d2 == 0) begin
                d2 = i;
            end
            if (d1 != 0 && i == d1 + 1) begin
                busy_gap = busy16 ? 0 : 1;
                drive(16, 1'b0, 64'h1000, 64'h0F00, 1'b0, 1'b0);
            end
        end
        chk("b2b_first_latency", 65'(d1), 65'd5);
        chk("b2b_no_idle_gap", 65'(busy_gap), 65'd0);
        chk("b2b_done_spacing", 65'(d2 - d1), 65'd5);
        chk("b2b_second_sum", 65'(sum16), 65'h1F00);

        // asynchronous reset during nibble 2
        @(negedge clk);
        drive(16, 1'b1, 64'h1234, 64'h5678, 1'b0, 1'b0);
        @(negedge clk);
        drive(16, 1'b0, 64'h1234, 64'h5678, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("pre_reset_busy", 65'(busy16), 65'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs",
            65'({sum16, busy16, done16, cout16, ovf16, zero16, aa16, ab16, acin16}), 65'd0);
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (done16) dcnt++;
        end
        chk("reset_no_done", 65'(dcnt), 65'd0);
        full_op(16, 64'h1234, 64'h1111, 1'b0, 1'b0, r);
        chk("post_reset_sum", 65'(r), 65'h2345);

        // randomized 64-bit operations
        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom, $urandom};
            rb = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) ra = {1'b0, {63{1'b1}}};
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            full_op(64, ra, rb, rs, rc, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
# nibble_serial_add_ctrl

Multi-cycle sequencer that performs a WIDTH-bit add/subtract by time-sharing one external 4-bit adder cell, one nibble per clock, LSB first. It sits between the LEGv8 ALU control and a single shared 4-bit adder slice, so wide additions need only one adder cell in area-constrained builds. It captures operands on a start handshake, drives the adder cell with a registered carry chain, and returns the sum and flags with a one-cycle done pulse.

## Interface
- WIDTH, 64, operand width in bits; must be a multiple of 4 and at least 8
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only in IDLE or DONE
- sub  in  1  1 = a − b (b inverted, carry-in forced 1); 0 = a + b + c_in
- c_in  in  1  carry-in for add; ignored when sub=1
- a, b  in  WIDTH  operands, sampled on the accepting edge only
- add_a, add_b  out  4  nibble operands to the adder cell (b already inverted when sub=1)
- add_cin  out  1  carry-in to the adder cell
- add_sum  in  4  sum from the adder cell (combinational from add_a/add_b/add_cin)
- add_cout  in  1  carry-out from the adder cell
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; results valid
- sum  out  WIDTH  result, held until the next accepted start
- c_out  out  1  final carry (for sub: 1 = no borrow)
- overflow  out  1  signed overflow
- zero  out  1  sum == 0

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE with start=1 → latch a, b, sub and the initial carry (sub ? 1 : c_in). Clear the nibble index to 0. Go to RUN.
- RUN, index k (0..N−1, N=WIDTH/4):
  - add_a = a_reg[4k+3:4k]
  - add_b = b_reg[4k+3:4k] XOR {4{sub_reg}}
  - add_cin = carry_reg
  - On each edge: sum_reg[4k+3:4k] ← add_sum; carry_reg ← add_cout; k ← k+1.
- On the k=N−1 edge, also register the flags:
  - c_out ← add_cout
  - overflow ← add_cout XOR (add_a[3] XOR add_b[3] XOR add_sum[3])
  - zero ← (full new sum == 0), including the final nibble
  - Then go to DONE.
- DONE: done=1 for exactly one cycle. Next state is RUN if start=1, otherwise IDLE.
- start in RUN is ignored; no queuing.
- add_a, add_b, add_cin are driven 0 outside RUN.
- sum, c_out, overflow and zero change only on the final RUN edge. They are not cleared by start.
- Wrap-around: the result is modulo 2^WIDTH; the carry is reported only via c_out.

## Timing
- Reset (async assert, any state): state=IDLE, busy=0, done=0, sum=0, c_out=0, overflow=0, zero=0, add_a=add_b=0, add_cin=0, index=0. Reset mid-RUN abandons the operation; no done is issued.
- start sampled at edge E0 → busy=1 from E0 through E(N−1)+. Nibble k is captured at edge E(k+1).
- After edge EN: state=DONE, done=1, busy=0, results valid.
- Latency is N+1 cycles from the accepting edge to done high. Throughput is one op per N+1 cycles with back-to-back starts; start held high in DONE restarts with no IDLE gap.
- The adder cell must settle within one clk period. The controller adds no combinational path from add_sum/add_cout to add_a/add_b/add_cin.

## Test plan
- WIDTH=16, add: a=0x00FF, b=0x0001, c_in=0 → done exactly 5 cycles after the start edge; sum=0x0100, c_out=0, overflow=0, zero=0; busy high for 4 cycles.
- WIDTH=16, add wrap: a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1, zero=1, overflow=0. Then a=0x7FFF, b=0x0000, c_in=1 → sum=0x8000, overflow=1, c_out=0.
- WIDTH=16, sub: a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, c_out=1, overflow=1. Then a=0x0003, b=0x0005, sub=1 → sum=0xFFFE, c_out=0, overflow=0.
- Handshake: pulse start again mid-RUN with different operands → ignored; the original result is returned and only one done pulse occurs. Hold start high through DONE → a second op begins with no IDLE cycle, and its done comes 5 cycles after the first done.
- Reset mid-op: deassert rst_n during nibble 2 → all outputs are 0 immediately (asynchronously) and no done is issued. After release, a new op (0x1234+0x1111) → sum=0x2345.
- Default WIDTH=64 with randomized a/b/sub/c_in (≥1000 ops) against a reference model → sum, c_out, overflow and zero match; done occurs 17 cycles after each accepted start.
